updown_mod_counter: RTL
=======================

// Module: updown_mod_counter
// PURPOSE
//  Fully synchronous, parametrised up/down modulo-N counter; next generation of the 4-bit async ripple counter.
//  Adds direction control, enable, parallel load, sync clear, wrap or saturate mode, terminal-count and overflow flags.
//  Used as the general event/divider counter in datapath and timer blocks; all state updates on one clock edge.
// PARAMETERS
//  WIDTH     4   counter width in bits (>=1)
//  MODULUS   16  count range 0..MODULUS-1; legal 2..2**WIDTH
//  SATURATE  0   0 = wrap at range ends; 1 = hold at range ends
//  RESET_VAL 0   value of q after rst/clr; must be < MODULUS
// PORTS
//  clk       in   1      clock, rising-edge active
//  rst       in   1      reset, asynchronous, active-high
//  clr       in   1      synchronous clear to RESET_VAL, highest sync priority
//  load      in   1      synchronous parallel load of load_val
//  load_val  in   WIDTH  load data; values >= MODULUS clamp to MODULUS-1
//  en        in   1      count enable
//  up        in   1      direction: 1 = increment, 0 = decrement
//  ovf_clr   in   1      clears sticky ovf flag
//  q         out  WIDTH  current count (registered)
//  tc        out  1      terminal count, combinational: en & ~clr & ~load & (up ? q==MODULUS-1 : q==0)
//  wrap      out  1      registered 1-cycle pulse, high the cycle after q wrapped (SATURATE=0 only)
//  ovf       out  1      sticky: set when count attempted past a range end (wrap or saturate hit)
// BEHAVIOUR
//  - rst asserted: q=RESET_VAL, wrap=0, ovf=0 immediately; held while rst high; tc follows its equation.
//  - Sync priority per rising edge: clr > load > en; none asserted -> q holds, wrap=0.
//  - clr: q<=RESET_VAL, wrap<=0, ovf<=0 (clr beats ovf_clr and any set event in the same cycle).
//  - load: q<=min(load_val, MODULUS-1); wrap<=0; ovf unchanged; no count that cycle.
//  - en & up: q<MODULUS-1 -> q+1; q==MODULUS-1 -> 0 (wrap mode, wrap<=1) or hold (sat mode).
//  - en & ~up: q>0 -> q-1; q==0 -> MODULUS-1 (wrap mode, wrap<=1) or hold (sat mode).
//  - ovf set on every tc-qualified count edge (both modes); ovf_clr clears it; set wins over ovf_clr same cycle.
//  - Latency: q changes 1 cycle after qualifying edge; tc is same-cycle; wrap lags the wrap edge by 1 cycle.
//  - Arithmetic in WIDTH+1 bits internally; no silent 2**WIDTH aliasing when MODULUS < 2**WIDTH.
//  - Direction change mid-count is legal and takes effect on that edge; no glitch states.
//  - MODULUS==2**WIDTH: natural binary wrap; SATURATE=1 holds at all-ones / zero.
//  - rst mid-operation: async clear overrides everything; first edge after deassert evaluates normally.
//  - Illegal params (MODULUS out of range, RESET_VAL>=MODULUS): elaboration-time error.
// STRUCTURE
//  - Shared package cnt_pkg: mode constants CNT_WRAP=0, CNT_SAT=1; function clamp_mod(val, mod).
//  - One sub-module: cnt_next_val (combinational next-state/terminal detect: q, up, MODULUS, SATURATE
//    -> q_next, at_end). Top holds the q/wrap/ovf registers and priority mux.
// TESTING
//  1. WIDTH=4,MODULUS=10,wrap: rst, en=1,up=1 for 12 clks -> q 0..9,0,1; tc high at q=9; wrap pulse after 9->0; ovf=1.
//  2. Same, up=0 from q=0 -> q 9,8,...; tc at q=0 same cycle; wrap pulse after 0->9.
//  3. SATURATE=1,MODULUS=10: count up 15 clks -> q sticks at 9, wrap never high, ovf=1; down -> sticks at 0.
//  4. load=1,load_val=13 (MODULUS=10) -> q=9; load with en=1 same cycle -> q=load value, no count; clr+load -> RESET_VAL.
//  5. ovf set, then ovf_clr=1 with en at q=9 same cycle -> ovf stays 1; ovf_clr alone next cycle -> ovf=0.
//  6. Assert rst asynchronously mid-count (between edges) at q=6 -> q=0, wrap=0, ovf=0 before next edge.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the up/down modulo counter family.
package cnt_pkg;

  // Range-end behaviour selectors for the SATURATE parameter
  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Clamp a value into 0..mod-1; values at or above mod become mod-1
  function automatic logic [31:0] clamp_mod(input logic [31:0] val, input logic [31:0] mod);
    logic [31:0] res;
    if (val >= mod) begin
      res = mod - 32'd1;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/cnt_next_val.sv
// Combinational next-count and range-end detect for the modulo counter.
// Arithmetic is done one bit wider than the count so that MODULUS < 2**WIDTH
// never aliases through a natural binary overflow.
module cnt_next_val
  import cnt_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_q_next,
  output logic             o_at_end
);

  localparam logic [WIDTH:0] LAST_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] ZERO_EXT = (WIDTH+1)'(0);

  logic [WIDTH:0] w_q_ext;
  logic [WIDTH:0] w_nxt_ext;
  logic           w_at_end;

  assign w_q_ext = {1'b0, i_q};

  // Step one place in the requested direction, wrapping or holding at the range ends
  always_comb begin
    w_at_end  = 1'b0;
    w_nxt_ext = w_q_ext;
    if (i_up) begin
      w_at_end = (w_q_ext == LAST_EXT);
      if (!w_at_end) begin
        w_nxt_ext = w_q_ext + ONE_EXT;
      end else if (SATURATE == CNT_SAT) begin
        w_nxt_ext = w_q_ext;
      end else begin
        w_nxt_ext = ZERO_EXT;
      end
    end else begin
      w_at_end = (w_q_ext == ZERO_EXT);
      if (!w_at_end) begin
        w_nxt_ext = w_q_ext - ONE_EXT;
      end else if (SATURATE == CNT_SAT) begin
        w_nxt_ext = w_q_ext;
      end else begin
        w_nxt_ext = LAST_EXT;
      end
    end
  end

  assign o_q_next = WIDTH'(w_nxt_ext);
  assign o_at_end = w_at_end;

endmodule

// File: rtl/updown_mod_counter.sv
// Synchronous parametrised up/down modulo-N counter with load, clear,
// wrap/saturate mode, terminal count, wrap pulse and sticky overflow.
module updown_mod_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int SATURATE  = CNT_WRAP,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // Reject impossible configurations while elaborating
  if (WIDTH < 1) begin : g_bad_width
    $error("updown_mod_counter: WIDTH must be >= 1");
  end
  if ((MODULUS < 2) || (longint'(MODULUS) > (longint'(1) << WIDTH))) begin : g_bad_mod
    $error("updown_mod_counter: MODULUS must lie in 2..2**WIDTH");
  end
  if ((RESET_VAL < 0) || (RESET_VAL >= MODULUS)) begin : g_bad_rst
    $error("updown_mod_counter: RESET_VAL must be below MODULUS");
  end
  if ((SATURATE != CNT_WRAP) && (SATURATE != CNT_SAT)) begin : g_bad_sat
    $error("updown_mod_counter: SATURATE must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] RST_Q     = WIDTH'(RESET_VAL);
  localparam logic             WRAP_MODE = (SATURATE == CNT_WRAP) ? 1'b1 : 1'b0;

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_ovf;

  logic [WIDTH-1:0] w_q_next;
  logic             w_at_end;
  logic [WIDTH-1:0] w_load_q;
  logic             w_tc;
  logic [WIDTH-1:0] w_q_d;
  logic             w_wrap_d;
  logic             w_ovf_d;

  cnt_next_val #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .SATURATE(SATURATE)
  ) u_next (
    .i_q     (r_q),
    .i_up    (up),
    .o_q_next(w_q_next),
    .o_at_end(w_at_end)
  );

  // Out-of-range load data lands on the top of the count range
  assign w_load_q = WIDTH'(clamp_mod(32'(load_val), 32'(MODULUS)));

  // A count edge that would step past a range end this cycle
  assign w_tc = en & ~clr & ~load & w_at_end;

  // Priority mux: clear beats load beats count; idle holds and drops the wrap pulse
  always_comb begin
    w_q_d    = r_q;
    w_wrap_d = 1'b0;
    if (clr) begin
      w_q_d = RST_Q;
    end else if (load) begin
      w_q_d = w_load_q;
    end else if (en) begin
      w_q_d    = w_q_next;
      w_wrap_d = w_at_end & WRAP_MODE;
    end else begin
      w_q_d = r_q;
    end
  end

  // Sticky overflow: clear wins outright, a range-end hit beats ovf_clr
  always_comb begin
    w_ovf_d = r_ovf;
    if (clr) begin
      w_ovf_d = 1'b0;
    end else if (w_tc) begin
      w_ovf_d = 1'b1;
    end else if (ovf_clr) begin
      w_ovf_d = 1'b0;
    end else begin
      w_ovf_d = r_ovf;
    end
  end

  // State registers with asynchronous reset to the configured start value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= RST_Q;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_q    <= w_q_d;
      r_wrap <= w_wrap_d;
      r_ovf  <= w_ovf_d;
    end
  end

  assign q    = r_q;
  assign tc   = w_tc;
  assign wrap = r_wrap;
  assign ovf  = r_ovf;

endmodule
